uart_rx: RTL and testbench

Serial receiver that sits directly downstream of the UART transmitter on the serial link. It recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from an asynchronous line at a fixed baud set by a clock-count parameter. Each byte is presented with a one-cycle `done` strobe. It is the receive half of the UART pair and closes the loop with the transmitter on the same 100 MHz / 9600-baud link.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 29 ++
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both halves of the UART pair.
//   rx_state_t           : receiver FSM states
//   DEFAULT_CLKS_PER_BIT : clock cycles per bit for 100 MHz / 9600 baud
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10417;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk   : destination clock
//   reset : synchronous, active-high; both flops reset to 1 (idle line level)
//   d     : asynchronous input
//   q     : synchronized output, two cycles behind d
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Both flops reset to 1 so a freshly reset receiver sees an idle line
  // rather than a phantom start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make meta->q a real two-stage pipeline;
      // blocking ones would collapse it into a single flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit.
//   CLKS_PER_BIT : clock cycles per bit, >= 4
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high
//   rx           : asynchronous serial line, idles high
//   data         : last correctly received byte, held until the next good frame
//   done         : one-cycle pulse, data valid from the same cycle
//   busy         : high while a frame is in START, DATA or STOP
//   frame_err    : one-cycle pulse when the stop bit is sampled low
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       done,
  output logic       busy,
  output logic       frame_err
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  // Terminal counts: the counter is cleared on entry and at every sample,
  // so a sample falls on the N-th edge when the count reads N-1.
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic            rx_s;
  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // Strobes default low so each assertion below lasts exactly one cycle.
      done      <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        // Re-check the start bit at its middle to reject short glitches.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt  <= '0;
            busy <= 1'b0;
            if (rx_s) begin
              data  <= shreg;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A line held low (break) must go high before a new start is accepted.
        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard testbench for uart_rx with CLKS_PER_BIT = 16.
// Stimulus builds each serial frame from bit boundaries (optionally jittered),
// pushes the expected pulse (kind, byte, cycle) and a monitor pops on every
// done/frame_err pulse.
module tb_uart_rx;

  localparam int C    = 16;
  localparam int HALF = C / 2;
  localparam int LAT  = 2 + HALF + 9 * C;  // start edge to stop-sample edge

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       done;
  logic       busy;
  logic       frame_err;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .done      (done),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] d;
    longint     at;
  } exp_t;

  exp_t       sb[$];
  longint     done_log[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  exp_t e;
  always @(negedge clk) begin
    if (!reset && (done || frame_err)) begin
      check("done_err_exclusive", longint'(done && frame_err), 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", longint'(frame_err) + 2 * longint'(done), 0);
      end else begin
        e = sb.pop_front();
        check("pulse_is_err", longint'(frame_err), longint'(e.err));
        check("pulse_cycle", cyc, e.at);
        check("data_at_pulse", longint'(data), longint'(e.d));
        if (done) done_log.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Drive one frame. Bit boundaries after the start edge move by up to +-jit
  // cycles. tail_low keeps the line low after the frame; busy_tail counts
  // cycles busy was seen high during that tail.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int jit,
                            input int tail_low, output int busy_tail);
    int   t[11];
    bit   lv[10];
    int   k;
    exp_t x;
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[i+1] = b[i];
    lv[9] = stop;
    t[0]  = 0;
    t[10] = 10 * C;
    for (int i = 1; i < 10; i++)
      t[i] = i * C + ((jit > 0) ? (int'($urandom_range(2 * jit)) - jit) : 0);
    busy_tail = 0;
    for (int c = 0; c < 10 * C + tail_low; c++) begin
      step();
      if (c == 0) begin
        x.err = !stop;
        x.d   = stop ? b : last_good;
        x.at  = cyc + 1 + LAT;  // start edge is the next posedge
        if (stop) last_good = b;
        sb.push_back(x);
      end
      if (c >= 10 * C) begin
        if (busy) busy_tail++;
        rx = 1'b0;
      end else begin
        k = 0;
        for (int i = 1; i < 10; i++) if (c >= t[i]) k = i;
        rx = lv[k];
      end
    end
    if (rx == 1'b0) begin
      step();
      rx = 1'b1;
    end
  endtask

  int     tail_busy;
  int     n0;
  int     busy_cnt;
  longint busy_first;
  longint t0;
  int     budget;
  logic [7:0] rb;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below %0d", cyc, 200000);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    idle(3);
    check("reset_data", longint'(data), 0);
    check("reset_done", longint'(done), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_frame_err", longint'(frame_err), 0);
    reset = 1'b0;
    idle(5);

    // Single frame with exact timing.
    send_frame(8'hA9, 1'b1, 0, 0, tail_busy);
    idle(4);

    // Back-to-back 8'h00 then 8'hFF: done pulses exactly 10 bit periods apart.
    n0 = done_log.size();
    send_frame(8'h00, 1'b1, 0, 0, tail_busy);
    send_frame(8'hFF, 1'b1, 0, 0, tail_busy);
    idle(4);
    check("b2b_done_count", longint'(done_log.size() - n0), 2);
    if (done_log.size() == n0 + 2)
      check("b2b_spacing", done_log[n0+1] - done_log[n0], 10 * C);
    check("b2b_last_data", longint'(data), 8'hFF);

    // Glitch: 3 low cycles. busy must be high for HALF cycles from START entry.
    busy_cnt   = 0;
    busy_first = -1;
    t0         = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (c == 0) t0 = cyc + 1;
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = cyc;
      end
      rx = (c < 3) ? 1'b0 : 1'b1;
    end
    check("glitch_busy_cycles", busy_cnt, HALF);
    check("glitch_busy_rise", busy_first, t0 + 2);
    check("glitch_data_kept", longint'(data), longint'(last_good));

    // Framing error with the line held low for 40 more cycles.
    send_frame(8'h5A, 1'b0, 0, 40, tail_busy);
    check("break_no_restart", tail_busy, 0);
    busy_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (busy) busy_cnt++;
    end
    check("break_idle_after_high", busy_cnt, 0);
    check("ferr_data_kept", longint'(data), longint'(last_good));
    send_frame(8'h96, 1'b1, 0, 0, tail_busy);
    idle(3);

    // Reset in the middle of data bit 4 of 8'h3C.
    for (int c = 0; c <= 5 * C + HALF; c++) begin
      step();
      rx = (c < C) ? 1'b0 : ((8'h3C >> (c / C - 1)) & 8'h01) != 0;
    end
    step();
    reset = 1'b1;
    rx    = 1'b1;
    step();
    check("midrst_data", longint'(data), 0);
    check("midrst_done", longint'(done), 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_frame_err", longint'(frame_err), 0);
    reset     = 1'b0;
    last_good = 8'h00;
    idle(5);
    send_frame(8'hC3, 1'b1, 0, 0, tail_busy);
    idle(3);
    check("after_reset_data", longint'(data), 8'hC3);

    // Jittered edges at the maximum tolerated offset.
    send_frame(8'h81, 1'b1, HALF - 2, 0, tail_busy);
    idle(3);
    check("jitter_data", longint'(data), 8'h81);

    // Random bytes, random jitter, random gaps, occasional framing errors.
    for (int n = 0; n < 10; n++) begin
      rb = 8'($urandom);
      send_frame(rb, ($urandom_range(4) != 0), int'($urandom_range(HALF - 2)), 0, tail_busy);
      idle(int'($urandom_range(20)));
    end

    // Drain the scoreboard within a bounded wait.
    budget = 0;
    while (sb.size() != 0 && budget < 400) begin
      step();
      budget++;
    end
    check("scoreboard_drained", longint'(sb.size()), 0);
    check("final_busy", longint'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
